data_memory_param: RTL

Parametrised successor to the 32x256 data memory in the single-cycle processor. Adds:
- byte addressing with little-endian byte/half/word stores and sign/zero-extended loads;
- a registered read port with a valid strobe;
- alignment and range error detection;
- a post-reset zero-initialisation sequencer.

It sits on the processor's load/store path between the ALU address output and the writeback mux.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/load_extract.sv | 29 ++
 rtl/data_memory_param.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the parametrised data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    lane_mask = 4'b0000;
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << offset;
      SZ_HALF: lane_mask = 4'b0011 << offset;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Store data replicated across lanes so any enabled lane sees its bytes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    lane_data = data;
    case (size)
      SZ_BYTE: lane_data = {4{data[7:0]}};
      SZ_HALF: lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane select with sign/zero extension for sub-word loads.
module load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] result_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];
    result_c  = word;
    case (size)
      SZ_BYTE: result_c = unsigned_ld ? {24'h000000, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: result_c = unsigned_ld ? {16'h0000, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
      default: result_c = word;
    endcase
  end

endmodule

// File: rtl/data_memory_param.sv
// Byte-addressed data memory with registered loads, error detection
// and a post-reset zero-fill sequencer.
module data_memory_param #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic                  ready,
  output logic                  err
);
  import dmem_pkg::*;

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  state_e           state, state_next;
  logic [IDX_W-1:0] init_cnt;

  logic [IDX_W-1:0] idx_c;
  logic [1:0]       offset_c;
  logic             out_of_range_c;
  logic             bad_size_c;
  logic             misalign_c;
  logic             reject_c;
  logic             do_store_c;
  logic             do_load_c;
  logic [31:0]      cur_word_c;
  logic [31:0]      bit_mask_c;
  logic [31:0]      merged_c;
  logic [31:0]      load_word_c;
  logic [3:0]       be_c;

  // Address decode and request legality.
  always_comb begin
    idx_c          = address[IDX_W+1:2];
    offset_c       = address[1:0];
    out_of_range_c = (address >> (IDX_W + 2)) != '0;
    bad_size_c     = (size == 2'b11);
    misalign_c     = ((size == SZ_HALF) && offset_c[0]) ||
                     ((size == SZ_WORD) && (offset_c != 2'b00));
    reject_c       = (state == ST_RUN) && (read_en || write_en) &&
                     (out_of_range_c || bad_size_c || misalign_c || (read_en && write_en));
    do_store_c     = (state == ST_RUN) && write_en && !reject_c;
    do_load_c      = (state == ST_RUN) && read_en && !reject_c;
  end

  // Read-modify-merge of the addressed word for partial stores.
  always_comb begin
    cur_word_c = mem[idx_c];
    be_c       = lane_mask(size, offset_c);
    bit_mask_c = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
    merged_c   = (cur_word_c & ~bit_mask_c) | (lane_data(size, write_data) & bit_mask_c);
  end

  load_extract u_load_extract (
    .word        (cur_word_c),
    .offset      (offset_c),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .result_c    (load_word_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_next;
  end

  // Leave INIT once the last word has been cleared.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == IDX_W'(DEPTH - 1)) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Zero-fill word counter.
  always_ff @(posedge clk) begin
    if (!rst_n)                 init_cnt <= '0;
    else if (state == ST_INIT)  init_cnt <= init_cnt + IDX_W'(1);
  end

  // Storage: zero-fill during INIT, merged stores in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) mem[init_cnt] <= '0;
      else if (do_store_c)  mem[idx_c]    <= merged_c;
    end
  end

  // Registered load result and status strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      err        <= 1'b0;
      ready      <= 1'b0;
    end else begin
      ready      <= (state_next == ST_RUN);
      err        <= reject_c;
      read_valid <= do_load_c;
      if (do_load_c) read_data <= load_word_c;
    end
  end

endmodule
